// File: rtl/step_pulse_generator.sv
// step_pulse_generator
// Converts a raw, bouncing pushbutton into clean one-clock strobes. One press
// gives exactly one Pulse. With RepeatEn high, a held button also produces
// repeat pulses after an initial delay. The block also exposes the debounced
// level and a modulo-256 tally of issued pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | button released, waiting for a debounced press
// HELD   | pressed, auto-repeat off; waits for release
// DELAY  | pressed, counting the initial delay before the first repeat
// REPEAT | pressed, issuing a repeat pulse every REPEAT_PERIOD cycles
module step_pulse_generator #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  input  logic       RepeatEn,
  output logic       Pulse,
  output logic       Pressed,
  output logic [7:0] PulseCount
);

  localparam int DB_W    = $clog2(DB_CYCLES);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  logic             sync0;
  logic             sync1;
  logic [DB_W-1:0]  db_cnt;
  logic [TMR_W-1:0] timer;
  state_t           state;

  // Two-flop synchronizer bringing the asynchronous button into the clock domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= BTN;
      sync1 <= sync0;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_cnt  <= '0;
      Pressed <= 1'b0;
    end else if (sync1 == Pressed) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      Pressed <= sync1;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Press/repeat FSM with registered Pulse and the pulse tally.
  // Release beats a RepeatEn drop, which beats timer expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      timer      <= '0;
      Pulse      <= 1'b0;
      PulseCount <= 8'd0;
    end else begin
      Pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (Pressed) begin
            Pulse      <= 1'b1;
            PulseCount <= PulseCount + 8'd1;
            timer      <= '0;
            state      <= RepeatEn ? DELAY : HELD;
          end
        end
        HELD: begin
          if (!Pressed) state <= IDLE;
        end
        DELAY: begin
          if (!Pressed) begin
            state <= IDLE;
          end else if (!RepeatEn) begin
            state <= HELD;
          end else if (timer == DELAY_LAST) begin
            Pulse      <= 1'b1;
            PulseCount <= PulseCount + 8'd1;
            timer      <= '0;
            state      <= REPEAT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        REPEAT: begin
          if (!Pressed) begin
            state <= IDLE;
          end else if (!RepeatEn) begin
            state <= HELD;
          end else if (timer == PERIOD_LAST) begin
            Pulse      <= 1'b1;
            PulseCount <= PulseCount + 8'd1;
            timer      <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Directed testbench for step_pulse_generator with default parameters.
// Edge n is the nth posedge after a stimulus change; outputs are sampled 1ns after each edge.
module tb_step_pulse_generator;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN;
  logic       RepeatEn;
  logic       Pulse;
  logic       Pressed;
  logic [7:0] PulseCount;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulse_q[$];
  int back_to_back = 0;
  logic prev_pulse = 1'b0;
  logic pressed_seen = 1'b0;

  step_pulse_generator dut (
    .CLK(CLK),
    .RST(RST),
    .BTN(BTN),
    .RepeatEn(RepeatEn),
    .Pulse(Pulse),
    .Pressed(Pressed),
    .PulseCount(PulseCount)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pq(input int i);
    if (i < pulse_q.size()) return pulse_q[i];
    return -1;
  endfunction

  // One clock edge, then sample and log pulses.
  task automatic step();
    @(posedge CLK);
    #1;
    edge_n++;
    if (Pulse === 1'b1) pulse_q.push_back(edge_n);
    if (Pulse === 1'b1 && prev_pulse) back_to_back++;
    prev_pulse = (Pulse === 1'b1);
    if (Pressed === 1'b1) pressed_seen = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_test();
    edge_n = 0;
    pulse_q.delete();
    pressed_seen = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    BTN = 1'b0;
    RepeatEn = 1'b0;
    steps(2);
    RST = 1'b0;
  endtask

  initial begin
    int exp4[9] = '{7, 15, 19, 23, 27, 31, 35, 39, 43};
    logic p5, p6, p45, p46;
    int n, c255, c256, e256;

    // 1: reset with button held, then one pulse after release of reset
    RST = 1'b1;
    BTN = 1'b1;
    RepeatEn = 1'b0;
    step();
    check_val("rst_pulse", int'(Pulse), 0);
    check_val("rst_pressed", int'(Pressed), 0);
    check_val("rst_count", int'(PulseCount), 0);
    step();
    RST = 1'b0;
    start_test();
    steps(12);
    check_val("t1_npulse", pulse_q.size(), 1);
    check_val("t1_pulse_edge", pq(0), 7);
    check_val("t1_count", int'(PulseCount), 1);
    BTN = 1'b0;
    steps(12);

    // 2: pure bounce never accepted
    do_reset();
    start_test();
    for (int i = 0; i < 10; i++) begin
      BTN = (i % 2 == 0);
      step();
    end
    BTN = 1'b0;
    steps(20);
    check_val("t2_npulse", pulse_q.size(), 0);
    check_val("t2_pressed_seen", int'(pressed_seen), 0);
    check_val("t2_count", int'(PulseCount), 0);

    // 3: single pulse without repeat; press and release latency
    do_reset();
    RepeatEn = 1'b0;
    BTN = 1'b1;
    start_test();
    p5 = 1'b0; p6 = 1'b0; p45 = 1'b0; p46 = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) BTN = 1'b0;
      step();
      if (i == 5) p5 = Pressed;
      if (i == 6) p6 = Pressed;
      if (i == 45) p45 = Pressed;
      if (i == 46) p46 = Pressed;
    end
    check_val("t3_pressed_e5", int'(p5), 0);
    check_val("t3_pressed_e6", int'(p6), 1);
    check_val("t3_pressed_e45", int'(p45), 1);
    check_val("t3_pressed_e46", int'(p46), 0);
    check_val("t3_npulse", pulse_q.size(), 1);
    check_val("t3_pulse_edge", pq(0), 7);
    check_val("t3_count", int'(PulseCount), 1);

    // 4a: auto-repeat pulse schedule
    do_reset();
    RepeatEn = 1'b1;
    BTN = 1'b1;
    start_test();
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) BTN = 1'b0;
      step();
    end
    check_val("t4_npulse", pulse_q.size(), 9);
    for (int i = 0; i < 9; i++) check_val($sformatf("t4_edge%0d", i), pq(i), exp4[i]);
    check_val("t4_count", int'(PulseCount), 9);

    // 4b: dropping RepeatEn in REPEAT parks in HELD; re-enabling does not restart
    do_reset();
    RepeatEn = 1'b1;
    BTN = 1'b1;
    start_test();
    for (int i = 1; i <= 45; i++) begin
      if (i == 21) RepeatEn = 1'b0;
      if (i == 26) RepeatEn = 1'b1;
      step();
    end
    check_val("t4b_npulse", pulse_q.size(), 3);
    check_val("t4b_last_edge", pq(2), 19);
    check_val("t4b_count", int'(PulseCount), 3);
    BTN = 1'b0;
    steps(12);

    // 5: Pressed drops at the edge before expiry 23 -> no pulse, back to IDLE
    do_reset();
    RepeatEn = 1'b1;
    BTN = 1'b1;
    start_test();
    p46 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 17) BTN = 1'b0;
      step();
      if (i == 22) p46 = Pressed;
    end
    check_val("t5_pressed_e22", int'(p46), 0);
    check_val("t5_npulse", pulse_q.size(), 3);
    check_val("t5_last_edge", pq(2), 19);
    BTN = 1'b1;
    start_test();
    steps(10);
    check_val("t5_repress_npulse", pulse_q.size(), 1);
    check_val("t5_repress_edge", pq(0), 7);
    check_val("t5_count", int'(PulseCount), 4);

    // 6a: reset landing on a repeat expiry edge, button still held
    do_reset();
    RepeatEn = 1'b1;
    BTN = 1'b1;
    start_test();
    steps(22);
    RST = 1'b1;
    step();
    check_val("t6_rst_pulse", int'(Pulse), 0);
    check_val("t6_rst_pressed", int'(Pressed), 0);
    check_val("t6_rst_count", int'(PulseCount), 0);
    RST = 1'b0;
    start_test();
    steps(14);
    check_val("t6_npulse", pulse_q.size(), 1);
    check_val("t6_pulse_edge", pq(0), 7);
    check_val("t6_count", int'(PulseCount), 1);

    // 6b: 256 pulses wrap the tally
    do_reset();
    RepeatEn = 1'b1;
    BTN = 1'b1;
    start_test();
    n = 0; c255 = -1; c256 = -1; e256 = -1;
    for (int i = 0; i < 1200 && n < 256; i++) begin
      step();
      if (Pulse === 1'b1) begin
        n++;
        if (n == 255) c255 = int'(PulseCount);
        if (n == 256) begin
          c256 = int'(PulseCount);
          e256 = edge_n;
        end
      end
    end
    check_val("wrap_npulse", n, 256);
    check_val("wrap_count255", c255, 255);
    check_val("wrap_count256", c256, 0);
    check_val("wrap_edge256", e256, 1031);
    BTN = 1'b0;
    steps(12);

    check_val("no_back_to_back", back_to_back, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
